cic_comb_decimator: RTL and testbench

- Back end of the CIC decimation filter: the rate-change and comb (differentiator) section.
- Input is the high-rate output of the last cic_integrator stage; output is the decimated, filtered sample stream.
- Block decimates by DECIM, then runs STAGES pipelined comb stages with differential delay DIFF_DELAY.
- Output is a strobed sample stream; there is no back-pressure.

---
 rtl/cic_pkg.sv | 25 ++
 rtl/cic_comb.sv | 47 ++++
 rtl/cic_comb_decimator.sv | 76 +++++++
 tb/tb_cic_comb_decimator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared CIC constants and sizing helpers, used by both the integrator chain and the comb back end.
package cic_pkg;

    localparam int unsigned CIC_STAGES     = 3;
    localparam int unsigned CIC_DECIM      = 64;
    localparam int unsigned CIC_DIFF_DELAY = 1;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned cic_width(input int unsigned bin, input int unsigned n,
                                              input int unsigned r, input int unsigned m);
        return bin + n * clog2(r * m);
    endfunction

endpackage

// File: rtl/cic_comb.sv
// One CIC comb (differentiator) stage: y = x - x delayed by DIFF_DELAY valid samples,
// registered, with the valid pipelined alongside.
module cic_comb #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned DIFF_DELAY = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DIFF_DELAY-1:0][WIDTH-1:0] del_q, del_d;
    logic [WIDTH-1:0]                 y_q, y_d;
    logic                             valid_q;

    // Delay line and output only move on valid so the differential delay counts samples, not cycles.
    always_comb begin
        del_d = del_q;
        y_d   = y_q;
        if (i_valid) begin
            y_d      = i_data - del_q[DIFF_DELAY-1];
            del_d[0] = i_data;
            for (int i = 1; i < DIFF_DELAY; i++) begin
                del_d[i] = del_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            del_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            del_q   <= del_d;
            y_q     <= y_d;
            valid_q <= i_valid;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = y_q;

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC back end: decimates the integrator output by DECIM, then runs STAGES pipelined comb stages.
// All arithmetic wraps modulo 2^WIDTH; width growth is the integrator's responsibility.
module cic_comb_decimator
    import cic_pkg::*;
#(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned STAGES     = CIC_STAGES,
    parameter int unsigned DECIM      = CIC_DECIM,
    parameter int unsigned DIFF_DELAY = CIC_DIFF_DELAY
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    localparam int unsigned     CntW   = (clog2(DECIM) > 0) ? clog2(DECIM) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DECIM - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             cap_valid_q, cap_valid_d;

    always_comb begin
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        cap_valid_d = 1'b0;
        if (i_en) begin
            if (cnt_q == CntMax) begin
                cnt_d       = '0;
                cap_d       = i_data;
                cap_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q       <= '0;
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    logic [STAGES:0][WIDTH-1:0] stage_data;
    logic [STAGES:0]            stage_valid;

    assign stage_data[0]  = cap_q;
    assign stage_valid[0] = cap_valid_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        cic_comb #(
            .WIDTH      (WIDTH),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_comb (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_valid (stage_valid[k]),
            .i_data  (stage_data[k]),
            .o_valid (stage_valid[k+1]),
            .o_data  (stage_data[k+1])
        );
    end

    assign o_data  = stage_data[STAGES];
    assign o_valid = stage_valid[STAGES];

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator across three configurations, with a behavioural
// integrator chain in front of one instance for the end-to-end gain check.
module tb_cic_comb_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // A: WIDTH=8, STAGES=1, DECIM=4, M=1
    logic       rst_a, en_a, vld_a;
    logic [7:0] data_a, out_a;
    // B: WIDTH=8, STAGES=3, DECIM=4, M=1, fed by three integrators
    logic       rst_b, en_b, vld_b;
    logic [7:0] data_b, out_b;
    // C: WIDTH=8, STAGES=3, DECIM=1, M=2
    logic       rst_c, en_c, vld_c;
    logic [7:0] data_c, out_c;

    cic_comb_decimator #(.WIDTH(8), .STAGES(1), .DECIM(4), .DIFF_DELAY(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_en(en_a), .i_data(data_a), .o_data(out_a), .o_valid(vld_a)
    );
    cic_comb_decimator #(.WIDTH(8), .STAGES(3), .DECIM(4), .DIFF_DELAY(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_en(en_b), .i_data(data_b), .o_data(out_b), .o_valid(vld_b)
    );
    cic_comb_decimator #(.WIDTH(8), .STAGES(3), .DECIM(1), .DIFF_DELAY(2)) u_dut_c (
        .i_clk(clk), .i_rst(rst_c), .i_en(en_c), .i_data(data_c), .o_data(out_c), .o_valid(vld_c)
    );

    logic [7:0] int1_q, int2_q, int3_q;
    always_ff @(posedge clk) begin
        if (rst_b) begin
            int1_q <= 8'd0;
            int2_q <= 8'd0;
            int3_q <= 8'd0;
        end else if (en_b) begin
            int1_q <= int1_q + 8'd1;
            int2_q <= int2_q + int1_q;
            int3_q <= int3_q + int2_q;
        end
    end
    assign data_b = int3_q;

    // Input history for config C; (1 - z^-2)^3 = 1 - 3z^-2 + 3z^-4 - z^-6.
    logic [7:0] hist [64];

    function automatic int at(input int i);
        return (i < 0) ? 0 : int'(hist[i]);
    endfunction

    function automatic logic [7:0] golden(input int n);
        return 8'(at(n) - 3 * at(n - 2) + 3 * at(n - 4) - at(n - 6));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        data_a = 8'h55; data_c = 8'h5a;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests += 4;
            if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_vld_a: got %b expected 0", vld_a); end
            if (out_a !== 8'd0) begin n_fail++; $display("FAIL reset_out_a: got %0d expected 0", out_a); end
            if (vld_c !== 1'b0) begin n_fail++; $display("FAIL reset_vld_c: got %b expected 0", vld_c); end
            if (out_c !== 8'd0) begin n_fail++; $display("FAIL reset_out_c: got %0d expected 0", out_c); end
        end
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    endtask

    // step: per-cycle input increment; captures 3,7,11,... give first output 3*step then 4*step.
    task automatic run_a(input string name, input int step, input int ncyc);
        int o;
        logic exp_v;
        logic [7:0] exp_d;
        bit first;
        rst_a = 1'b1; en_a = 1'b0;
        tick();
        exp_d = 8'd0;
        first = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            rst_a = 1'b0; en_a = 1'b1; data_a = 8'(step * c);
            tick();
            o = c + 1;
            exp_v = (o >= 5) && ((o - 5) % 4 == 0);
            if (exp_v) begin
                exp_d = first ? 8'(3 * step) : 8'(4 * step);
                first = 1'b0;
            end
            n_tests += 2;
            if (vld_a !== exp_v) begin
                n_fail++; $display("FAIL %s_valid cyc %0d: got %b expected %b", name, o, vld_a, exp_v);
            end
            if (out_a !== exp_d) begin
                n_fail++; $display("FAIL %s_data cyc %0d: got %0d expected %0d", name, o, out_a, exp_d);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_ramp();
        run_a("ramp", 1, 20);
    endtask

    task automatic test_wrap();
        run_a("wrap", 10, 48);
    endtask

    task automatic test_gapped();
        int o;
        logic exp_v;
        logic [7:0] exp_d;
        bit first;
        rst_a = 1'b1; en_a = 1'b0;
        tick();
        exp_d = 8'd0;
        first = 1'b1;
        for (int c = 0; c < 40; c++) begin
            rst_a = 1'b0;
            en_a = (c % 2 == 0);
            data_a = en_a ? 8'(c / 2) : 8'haa;
            tick();
            o = c + 1;
            exp_v = (o >= 8) && ((o - 8) % 8 == 0);
            if (exp_v) begin
                exp_d = first ? 8'd3 : 8'd4;
                first = 1'b0;
            end
            n_tests += 2;
            if (vld_a !== exp_v) begin
                n_fail++; $display("FAIL gapped_valid cyc %0d: got %b expected %b", o, vld_a, exp_v);
            end
            if (out_a !== exp_d) begin
                n_fail++; $display("FAIL gapped_data cyc %0d: got %0d expected %0d", o, out_a, exp_d);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_dc_gain();
        int n_out;
        rst_b = 1'b1; en_b = 1'b0;
        tick();
        n_out = 0;
        for (int c = 0; c < 120; c++) begin
            rst_b = 1'b0; en_b = 1'b1;
            tick();
            if (vld_b === 1'b1) begin
                n_out++;
                if (n_out > 8) begin
                    n_tests++;
                    if (out_b !== 8'd64) begin
                        n_fail++; $display("FAIL dc_gain out %0d: got %0d expected 64", n_out, out_b);
                    end
                end
            end
        end
        n_tests++;
        if (n_out != 29) begin
            n_fail++; $display("FAIL dc_gain_count: got %0d expected 29", n_out);
        end
        en_b = 1'b0;
    endtask

    // Feeds hist[0..ncyc-1] into C starting right after reset; output n appears 4 cycles after capture.
    task automatic run_c(input string name, input int ncyc);
        logic exp_v;
        logic [7:0] exp_d;
        exp_d = 8'd0;
        for (int c = 0; c < ncyc; c++) begin
            rst_c = 1'b0; en_c = 1'b1; data_c = hist[c];
            tick();
            exp_v = (c >= 3);
            if (exp_v) exp_d = golden(c - 3);
            n_tests += 2;
            if (vld_c !== exp_v) begin
                n_fail++; $display("FAIL %s_valid step %0d: got %b expected %b", name, c, vld_c, exp_v);
            end
            if (out_c !== exp_d) begin
                n_fail++; $display("FAIL %s_data step %0d: got %0d expected %0d", name, c, out_c, exp_d);
            end
        end
        en_c = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) hist[i] = 8'($urandom);
        rst_c = 1'b1; en_c = 1'b0;
        tick();
        run_c("b2b", 40);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 64; i++) hist[i] = 8'($urandom);
        rst_c = 1'b1; en_c = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            rst_c = 1'b0; en_c = 1'b1; data_c = hist[c];
            tick();
        end
        // Reset coincides with a capture; both the capture and all in-flight samples must vanish.
        rst_c = 1'b1; en_c = 1'b1; data_c = 8'h77;
        tick();
        n_tests += 2;
        if (vld_c !== 1'b0) begin n_fail++; $display("FAIL mid_reset_vld: got %b expected 0", vld_c); end
        if (out_c !== 8'd0) begin n_fail++; $display("FAIL mid_reset_out: got %0d expected 0", out_c); end
        for (int i = 0; i < 64; i++) hist[i] = 8'($urandom);
        run_c("mid_reset", 12);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        data_a = 8'd0; data_c = 8'd0;
        test_reset();
        test_ramp();
        test_wrap();
        test_gapped();
        test_dc_gain();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
